// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed scan scheduler for a 4-digit 7-segment display.
// One shared hex nibble is driven per digit slot. The displayed value is held in a
// shadow register that is reloaded only at frame boundaries, so no frame shows a
// mix of old and new digits. Leading-zero blanking, per-digit decimal points and
// whole-display blink are applied on the anode enables. Every output is registered.

module disp_scan_ctrl #(
  parameter int DIV_CNT      = 50000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] hexs,
  input  logic        upd_req,
  output logic        upd_ack,
  input  logic        blank_lz,
  input  logic        blink_en,
  input  logic [3:0]  point,
  output logic [3:0]  hex,
  output logic [3:0]  an,
  output logic        dp,
  output logic [1:0]  scan,
  output logic        frame_done
);

  localparam int            PW        = (DIV_CNT > 2) ? $clog2(DIV_CNT) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV_CNT - 1);
  localparam int            BW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLK_LAST  = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pre;
  logic          tick;
  logic          frame_end;
  logic [15:0]   shadow;
  logic [BW-1:0] blk_cnt;
  logic          blk_phase;
  logic [3:0]    nib_cur;
  logic [3:0]    lz_dark;
  logic [3:0]    an_nxt;

  assign tick      = (pre == PRE_LAST);
  assign frame_end = tick && (scan == 2'd3);

  // Prescaler: one tick per digit slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Digit index advances on each tick; the 2-bit register wraps 3 -> 0 on its own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan <= 2'd0;
    end else if (tick) begin
      scan <= scan + 2'd1;
    end
  end

  // Frame boundary: pulse frame_done and, if requested, capture the new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_done <= 1'b0;
      upd_ack    <= 1'b0;
      shadow     <= 16'h0000;
    end else begin
      frame_done <= frame_end;
      upd_ack    <= frame_end && upd_req;
      if (frame_end && upd_req) begin
        shadow <= hexs;
      end
    end
  end

  // Blink timebase counts whole frames and runs even while blink is disabled,
  // so enabling blink never starts mid-way through a stale half-period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_cnt   <= '0;
      blk_phase <= 1'b0;
    end else if (frame_end) begin
      if (blk_cnt == BLK_LAST) begin
        blk_cnt   <= '0;
        blk_phase <= ~blk_phase;
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
      end
    end
  end

  // Select the active nibble and work out which digits are dark this slot.
  always_comb begin
    nib_cur = 4'h0;
    case (scan)
      2'd0: nib_cur = shadow[3:0];
      2'd1: nib_cur = shadow[7:4];
      2'd2: nib_cur = shadow[11:8];
      2'd3: nib_cur = shadow[15:12];
      default: nib_cur = 4'h0;
    endcase

    // A digit is a leading zero only if it and every digit to its left are zero.
    lz_dark    = 4'b0000;
    lz_dark[3] = (shadow[15:12] == 4'h0);
    lz_dark[2] = lz_dark[3] && (shadow[11:8] == 4'h0);
    lz_dark[1] = lz_dark[2] && (shadow[7:4] == 4'h0);
    lz_dark[0] = 1'b0;

    an_nxt = ~(4'b0001 << scan);
    if ((blink_en && blk_phase) || (blank_lz && lz_dark[scan])) begin
      an_nxt = 4'b1111;
    end
  end

  // Output register: hex/an/dp follow the current slot with one cycle of latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hex <= 4'h0;
      an  <= 4'b1111;
      dp  <= 1'b1;
    end else begin
      hex <= nib_cur;
      an  <= an_nxt;
      dp  <= ~point[scan];
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with DIV_CNT=4, BLINK_FRAMES=2 (16-cycle frames).
// Expected per-slot values are written as hand-computed constants per frame.

module tb_disp_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] hexs;
  logic        upd_req;
  logic        upd_ack;
  logic        blank_lz;
  logic        blink_en;
  logic [3:0]  point;
  logic [3:0]  hex;
  logic [3:0]  an;
  logic        dp;
  logic [1:0]  scan;
  logic        frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  disp_scan_ctrl #(
    .DIV_CNT      (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hexs       (hexs),
    .upd_req    (upd_req),
    .upd_ack    (upd_ack),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .point      (point),
    .hex        (hex),
    .an         (an),
    .dp         (dp),
    .scan       (scan),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one 16-cycle frame starting right after a frame boundary (or reset release).
  // Sample j (after the j-th rising edge) shows the outputs for slot (j-1)/4.
  // hx/anx hold four nibbles indexed by slot; dpx holds one dp bit per slot.
  // If req_on_at is nonzero, upd_req is raised after sample req_on_at.
  task automatic frame_chk(input string tag, input logic [15:0] hx, input logic [15:0] anx,
                           input logic [3:0] dpx, input logic ackx, input int req_on_at);
    for (int j = 1; j <= 16; j++) begin
      int s;
      @(negedge clk);
      s = (j - 1) / 4;
      chk_eq($sformatf("%s_hex_j%0d", tag, j), 16'(hex), 16'(hx[4*s +: 4]));
      chk_eq($sformatf("%s_an_j%0d", tag, j), 16'(an), 16'(anx[4*s +: 4]));
      chk_eq($sformatf("%s_dp_j%0d", tag, j), 16'(dp), 16'(dpx[s]));
      chk_eq($sformatf("%s_scan_j%0d", tag, j), 16'(scan), 16'((j / 4) % 4));
      chk_eq($sformatf("%s_fdone_j%0d", tag, j), 16'(frame_done), 16'(j == 16));
      chk_eq($sformatf("%s_ack_j%0d", tag, j), 16'(upd_ack), (j == 16) ? 16'(ackx) : 16'd0);
      if (j == req_on_at) upd_req = 1'b1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    hexs     = 16'h0000;
    upd_req  = 1'b0;
    blank_lz = 1'b0;
    blink_en = 1'b0;
    point    = 4'b0000;

    repeat (3) @(negedge clk);
    chk_eq("rst_an",    16'(an),         16'hF);
    chk_eq("rst_hex",   16'(hex),        16'h0);
    chk_eq("rst_dp",    16'(dp),         16'h1);
    chk_eq("rst_scan",  16'(scan),       16'h0);
    chk_eq("rst_ack",   16'(upd_ack),    16'h0);
    chk_eq("rst_fdone", 16'(frame_done), 16'h0);
    rst = 1'b1;

    // Plain scanning with an all-zero shadow.
    frame_chk("t1a", 16'h0000, 16'h7BDE, 4'hF, 1'b0, 0);

    // Capture 1234 requested mid-frame; visible only from the next frame.
    hexs = 16'h1234;
    frame_chk("t2a", 16'h0000, 16'h7BDE, 4'hF, 1'b1, 6);
    upd_req = 1'b0;
    frame_chk("t2b", 16'h1234, 16'h7BDE, 4'hF, 1'b0, 0);

    // New input without a request is ignored.
    hexs = 16'hFFFF;
    frame_chk("t3a", 16'h1234, 16'h7BDE, 4'hF, 1'b0, 0);
    frame_chk("t3b", 16'h1234, 16'h7BDE, 4'hF, 1'b0, 0);

    // Request raised in the frame_end cycle itself is accepted; then blanking on 0050.
    hexs     = 16'h0050;
    blank_lz = 1'b1;
    frame_chk("t4a", 16'h1234, 16'h7BDE, 4'hF, 1'b1, 15);
    upd_req = 1'b0;
    frame_chk("t4b", 16'h0050, 16'hFFDE, 4'hF, 1'b0, 0);

    // All-zero shadow: only digit 0 stays lit.
    hexs = 16'h0000;
    frame_chk("t4c", 16'h0050, 16'hFFDE, 4'hF, 1'b1, 1);
    upd_req = 1'b0;
    frame_chk("t4d", 16'h0000, 16'hFFFE, 4'hF, 1'b0, 0);

    // Blink: phase toggles at every second frame_end (after frames 2,4,6,...).
    blank_lz = 1'b0;
    blink_en = 1'b1;
    point    = 4'b0100;
    frame_chk("t5a", 16'h0000, 16'h7BDE, 4'b1011, 1'b0, 0);
    frame_chk("t5b", 16'h0000, 16'hFFFF, 4'b1011, 1'b0, 0);
    frame_chk("t5c", 16'h0000, 16'hFFFF, 4'b1011, 1'b0, 0);
    frame_chk("t5d", 16'h0000, 16'h7BDE, 4'b1011, 1'b0, 0);
    frame_chk("t5e", 16'h0000, 16'h7BDE, 4'b1011, 1'b0, 0);
    frame_chk("t5f", 16'h0000, 16'hFFFF, 4'b1011, 1'b0, 0);

    // Load a nonzero value, then reset mid-frame with a request pending.
    blink_en = 1'b0;
    point    = 4'b0000;
    hexs     = 16'h1234;
    frame_chk("t6a", 16'h0000, 16'h7BDE, 4'hF, 1'b1, 1);
    upd_req = 1'b0;
    frame_chk("t6b", 16'h1234, 16'h7BDE, 4'hF, 1'b0, 0);

    hexs    = 16'hABCD;
    upd_req = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_eq("t6_rst_an",    16'(an),         16'hF);
    chk_eq("t6_rst_hex",   16'(hex),        16'h0);
    chk_eq("t6_rst_dp",    16'(dp),         16'h1);
    chk_eq("t6_rst_scan",  16'(scan),       16'h0);
    chk_eq("t6_rst_ack",   16'(upd_ack),    16'h0);
    chk_eq("t6_rst_fdone", 16'(frame_done), 16'h0);
    repeat (2) begin
      @(negedge clk);
      chk_eq("t6_rst_hold_ack", 16'(upd_ack), 16'h0);
      chk_eq("t6_rst_hold_an",  16'(an),      16'hF);
    end
    rst = 1'b1;
    frame_chk("t6c", 16'h0000, 16'h7BDE, 4'hF, 1'b1, 0);
    upd_req = 1'b0;
    frame_chk("t6d", 16'hABCD, 16'h7BDE, 4'hF, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
